// File: rtl/onchip_mem_loader_pkg.sv
// onchip_mem_loader shared types and constants.
// Optional checksum state: ONCHIP_MEM_LOADER_CSUM_EN.
package onchip_mem_loader_pkg;

  localparam int ADDR_W_DEF     = 13;
  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

`ifdef ONCHIP_MEM_LOADER_CSUM_EN
  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHECK,
    FIN
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FIN
  } state_t;
`endif

endpackage

// File: rtl/onchip_mem_loader_if.sv
// Byte stream and memory slave-port bundle.
// master = loader side, slave = stream source / memory side.
interface onchip_mem_loader_if
  import onchip_mem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [7:0]                in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [ADDR_W-1:0]         mem_address;
  logic [BYTES_PER_WORD-1:0] mem_byteenable;
  logic [DATA_W-1:0]         mem_writedata;
  logic                      mem_chipselect;
  logic                      mem_write;
  logic                      mem_clken;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_address,
    output mem_byteenable,
    output mem_writedata,
    output mem_chipselect,
    output mem_write,
    output mem_clken
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_address,
    input  mem_byteenable,
    input  mem_writedata,
    input  mem_chipselect,
    input  mem_write,
    input  mem_clken
  );

endinterface

// File: rtl/onchip_mem_loader_packer.sv
// Little-endian byte-to-word packer.
// Presents the completed word combinationally on the completing byte.
module onchip_mem_loader_packer
  import onchip_mem_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      accept,
  input  logic                      last,
  input  logic [7:0]                data,
  output logic                      word_valid,
  output logic [DATA_W-1:0]         word_data,
  output logic [BYTES_PER_WORD-1:0] word_be
);

  logic [LANE_W-1:0] lane;
  logic [DATA_W-1:0] pack;

  assign word_valid = accept &&
                      ((lane == LANE_W'(BYTES_PER_WORD - 1)) || last);

  // merge the incoming byte into its lane; lanes not yet seen stay 0
  always_comb begin
    word_data = pack | (DATA_W'(data) << {lane, 3'b000});
    word_be   = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      word_be[i] = (i <= int'(lane));
  end

  // lane counter and pack register, emptied after each finished word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      pack <= '0;
    end else if (clear || word_valid) begin
      lane <= '0;
      pack <= '0;
    end else if (accept) begin
      lane <= lane + LANE_W'(1);
      pack <= word_data;
    end
  end

endmodule

// File: rtl/onchip_mem_loader.sv
// Streaming boot loader into 32-bit on-chip memory.
// Define ONCHIP_MEM_LOADER_CSUM_EN for a trailing checksum byte.
module onchip_mem_loader
  import onchip_mem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = 15
)(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [LEN_W-1:0]   byte_count,
  input  logic               abort,
  onchip_mem_loader_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               error
);

  state_t                    state;
  logic [LEN_W-1:0]          remain;
  logic [ADDR_W-1:0]         addr;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [BYTES_PER_WORD-1:0] wr_be;
  logic                      wr;
  logic                      go;
  logic                      take;
  logic                      byte_acc;
  logic                      last;
  logic                      word_valid;
  logic [DATA_W-1:0]         word_data;
  logic [BYTES_PER_WORD-1:0] word_be;

  assign go       = (state == IDLE) && start && !abort;
  assign take     = bus.in_valid && bus.in_ready && !abort;
  assign byte_acc = take && (state == COLLECT);
  assign last     = (remain == LEN_W'(1));
  assign busy     = (state != IDLE);

`ifdef ONCHIP_MEM_LOADER_CSUM_EN
  assign bus.in_ready = (state == COLLECT) || (state == CHECK);
`else
  assign bus.in_ready = (state == COLLECT);
`endif

  assign bus.mem_address    = wr_addr;
  assign bus.mem_writedata  = wr_data;
  assign bus.mem_byteenable = wr_be;
  assign bus.mem_write      = wr;
  assign bus.mem_chipselect = wr;
  assign bus.mem_clken      = 1'b1;

  onchip_mem_loader_packer u_packer (
    .clk        (clk),
    .rst_n      (reset_n),
    .clear      (go || abort),
    .accept     (byte_acc),
    .last       (last),
    .data       (bus.in_data),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_be    (word_be)
  );

  // load sequencing, word address counter and registered bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      remain  <= '0;
      addr    <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_be   <= '0;
      wr      <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr   <= 1'b0;
      done <= 1'b0;
      if (word_valid) begin
        wr_addr <= addr;
        wr_data <= word_data;
        wr_be   <= word_be;
        wr      <= 1'b1;
        addr    <= addr + ADDR_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (go) begin
            remain <= byte_count;
            addr   <= base_addr;
            if (byte_count == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (abort) begin
            state <= IDLE;
          end else if (byte_acc) begin
            remain <= remain - LEN_W'(1);
            if (last) begin
`ifdef ONCHIP_MEM_LOADER_CSUM_EN
              state <= CHECK;
`else
              state <= FIN;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef ONCHIP_MEM_LOADER_CSUM_EN
        CHECK: begin
          if (abort) begin
            state <= IDLE;
          end else if (take) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
`endif
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ONCHIP_MEM_LOADER_CSUM_EN
  logic [7:0] sum;

  // running payload sum; sticky mismatch flag on the checksum byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum   <= '0;
      error <= 1'b0;
    end else if (go) begin
      sum   <= '0;
      error <= 1'b0;
    end else if (byte_acc) begin
      sum <= sum + bus.in_data;
    end else if (take && (state == CHECK)) begin
      error <= ((sum + bus.in_data) != 8'h00);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/onchip_mem_loader.md
# onchip_mem_loader

Streaming boot loader that sits directly upstream of the 8192×32 single-port on-chip memory in the Nios II SoC. It accepts a byte stream with a ready/valid handshake and packs bytes little-endian into 32-bit words. It writes each word through the memory's slave port (address, byteenable, chipselect, write, writedata) at consecutive word addresses from a programmable base. An optional trailing checksum byte validates the image.

## Interface
Parameters:
- ADDR_W, 13: word-address width; the address space wraps at 2^ADDR_W.
- LEN_W, 15: width of the byte-count input; max 32767 bytes.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled on start.
- byte_count  in  LEN_W  payload length in bytes; sampled on start.
- abort  in  1  ends the load and returns the block to IDLE.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a byte this cycle.
- mem_address  out  ADDR_W  to memory address.
- mem_byteenable  out  4  to memory byteenable.
- mem_writedata  out  32  to memory writedata.
- mem_chipselect  out  1  equals mem_write.
- mem_write  out  1  one-cycle write strobe.
- mem_clken  out  1  constant 1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  checksum mismatch; sticky until the next start.

## Operation
- States: IDLE, COLLECT, CHECK (only with checksum), FIN.
- IDLE:
  - start with byte_count≠0 latches base_addr and byte_count, clears the pack register, sum and error, and goes to COLLECT.
  - start with byte_count=0 goes straight to FIN with no write.
  - start outside IDLE is ignored.
- COLLECT:
  - in_ready=1. A byte is accepted on in_valid&in_ready.
  - Byte lane i (0..3) maps to writedata[8i+7:8i] and byteenable[i].
  - The 4th byte of a word, or the final payload byte, loads the output registers. mem_write pulses the next cycle and the word address increments modulo 2^ADDR_W.
  - A partial tail word carries byteenable only for the lanes received; the other lanes of writedata are 0.
  - The pack register is separate from the output registers, so bytes may arrive back-to-back with no stall.
  - After the last payload byte: go to CHECK if checksum is enabled, else FIN.
- CHECK: in_ready=1. On acceptance, error is set if (sum of payload + checksum byte) mod 256 ≠ 0. Then go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- abort in any non-IDLE state:
  - go to IDLE and discard the partial word; done does not pulse.
  - A mem_write already asserted in that cycle completes unchanged.
- abort and start in the same cycle while in IDLE: abort wins and start is ignored.

## Timing
- Reset values: all outputs 0 except mem_clken=1. State IDLE, counters 0.
- Byte-to-write latency: if the completing byte is accepted at edge k, mem_write is high for the cycle after edge k.
- Without checksum, done coincides with the final mem_write cycle.
- With checksum, done is high in the cycle after the checksum byte is accepted. error is valid with done and held.
- byte_count=0: done in the cycle after the start edge.
- Peak throughput: one byte per cycle, one word write per 4 cycles.
- Reset mid-operation clears all state immediately. No write is issued after reset is released.

## Configuration
- ONCHIP_MEM_LOADER_CSUM_EN defined: the CHECK state exists, one checksum byte follows the payload, and error is driven as above.
- ONCHIP_MEM_LOADER_CSUM_EN undefined: there is no CHECK state and no sum register, and error is tied to 0.

## Structure
- Package onchip_mem_loader_pkg holds:
  - state enum
  - ADDR_W_DEF=13
  - DATA_W=32
  - BYTES_PER_WORD=4
- Sub-module onchip_mem_loader_packer holds the lane counter, pack register and tail byteenable generation. The FSM, address counter and checksum stay in the top level.

## Test plan
- base=0x0010, count=8, bytes 01..08 back-to-back -> writes (0x0010, 0x04030201, be F) and (0x0011, 0x08070605, be F). done coincides with the second write.
- count=6, bytes 01..06 -> second write has data 0x00000605 and be 0x3.
- base=0x1FFF, count=8 -> write addresses 0x1FFF then 0x0000.
- in_valid gaps of 3 cycles between bytes, and a start pulse while busy -> writes as in case 1, and the second start is ignored.
- ONCHIP_MEM_LOADER_CSUM_EN, bytes 01 02 03 04:
  - checksum 0xF6 -> error=0.
  - checksum 0x00 -> error=1 with done.
- reset_n low after 2 bytes -> all outputs 0 at once with no write. Then count=0 -> done one cycle after start and no write.
